vga_frame_reader: RTL and testbench
===================================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- H_VIS 640, visible pixels per line
- H_FP 16, front porch
- H_SYNC 96, sync width
- H_BP 48, back porch
- V_VIS 480, visible lines
- V_FP 10, front porch lines
- V_SYNC 2, sync lines
- V_BP 33, back porch lines
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  pixel clock, sole clock
- rst  in  1  reset, asynchronous, active-high
- CURRENT_WIDTH  in  10  width of processed image in frame RAM
- CURRENT_HEIGHT  in  10  height of processed image in frame RAM
- color_in  in  8  RAM read data; synchronous RAM, valid 1 clk after rd_addr
- rd_addr  out  19  frame RAM read address, linear row-major
- vga_hsync  out  1  horizontal sync, active-low
- vga_vsync  out  1  vertical sync, active-low
- vga_blank_n  out  1  high in visible area
- vga_r, vga_g, vga_b  out  8 each  grayscale pixel
- frame_done  out  1  one-clk pulse at end of last visible line

Function
REQ-003 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment when h_cnt wraps, counting 0..524 and wrapping to 0.
REQ-004 Visible area SHALL be h_cnt<640 and v_cnt<480.
REQ-005 hsync SHALL be low for h_cnt in 656..751; vsync SHALL be low for v_cnt in 490..491.
REQ-006 At h_cnt=0,v_cnt=0, the block SHALL latch CURRENT_WIDTH/HEIGHT into w_lat/h_lat; dimension changes at any other time SHALL take effect only at the next frame start.
REQ-007 Dimensions SHALL be valid iff 1<=w_lat<=640 and 1<=h_lat<=480; if invalid, the whole frame SHALL be black and rd_addr SHALL be 0.
REQ-008 Origin SHALL be x0=floor((640-w_lat)/2), y0=floor((480-h_lat)/2), computed at frame start.
REQ-009 in_image SHALL be true iff dims are valid, x0<=h_cnt<x0+w_lat, and y0<=v_cnt<y0+h_lat.
REQ-010 When in_image, rd_addr SHALL equal (v_cnt-y0)*w_lat+(h_cnt-x0), in the same cycle as the counters; otherwise rd_addr SHALL be 0.
REQ-011 Address SHALL be generated incrementally (row-base accumulator plus column counter), with no multiplier.
REQ-012 Video outputs for position (h,v) SHALL appear exactly 2 clk after h_cnt=h,v_cnt=v: stage 1 is the RAM read, stage 2 is the output registers. hsync, vsync, blank_n and rgb SHALL be delayed identically so they stay mutually aligned.
REQ-013 rgb SHALL be {color_in,color_in,color_in} when the delayed in_image is true, else 0x00 on all channels.
REQ-014 rgb SHALL be 0 whenever the delayed blank_n is low.
REQ-015 frame_done SHALL be high for exactly one clk, registered, in the cycle after h_cnt=799,v_cnt=479, once per frame.
REQ-016 No handshake with the writer SHALL exist; RAM contents changing mid-frame SHALL be displayed as read, with no stalling.

Reset
REQ-017 While rst=1, all of the following SHALL hold immediately, asynchronously:
- h_cnt=0, v_cnt=0, pipeline cleared
- rd_addr=0
- vga_hsync=1, vga_vsync=1, vga_blank_n=0
- rgb=0, frame_done=0
- w_lat=0, h_lat=0 (invalid, so black)
REQ-018 After rst falls, counting SHALL begin at the first rising clk, and the first frame SHALL latch dimensions at h_cnt=0,v_cnt=0.
REQ-019 Reset asserted mid-line or mid-frame SHALL abort the frame with no partial-state residue.

Verification
REQ-020 Reset: assert rst mid-line -> all outputs at their REQ-017 values within the same cycle; after release, 2 full frames of correct timing.
REQ-021 Timing: over 2 frames, with any dimensions -> the bench SHALL check each of:
- hsync low 96 of every 800 clk
- vsync low 2 lines of every 525
- blank_n high 640 clk/line on 480 lines
- frame_done once per 420000 clk
REQ-022 160x120 image: rd_addr=0 at (240,180) and 19199 at (399,299); RAM model returns 0x5A -> rgb 0x5A5A5A 2 clk later; (239,180) and (400,180) -> rgb 0.
REQ-023 Odd size 161x121: x0=239, y0=179; last pixel address 19480 at (399,299).
REQ-024 Change CURRENT_WIDTH 160->320 at v_cnt=200 -> rest of frame still uses width 160 (x0=240); next frame uses x0=160 with address stride 320.
REQ-025 Illegal dims (w=0; w=641; h=481) -> entire frame rgb=0, rd_addr=0, sync timing unchanged.

Source files
------------

// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
//
// Scans a VGA raster and fetches a centred grayscale image from a frame RAM.
// The image size is sampled once per frame (at the first pixel clock of the
// frame). The image is placed in the middle of the visible area, and a linear
// row-major RAM address is produced for every pixel inside it. The RAM returns
// data one clock after the address. The video outputs are registered once
// more, so every output for raster position (h,v) appears two clocks after
// the counters were at (h,v).
//
// Ports
//   clk            pixel clock (sole clock)
//   rst            asynchronous active-high reset
//   CURRENT_WIDTH  width of the image held in frame RAM (1..H_VIS is valid)
//   CURRENT_HEIGHT height of the image held in frame RAM (1..V_VIS is valid)
//   color_in       RAM read data, valid one clock after rd_addr
//   rd_addr        RAM read address, 0 outside the image
//   vga_hsync      horizontal sync, active-low
//   vga_vsync      vertical sync, active-low
//   vga_blank_n    high inside the visible area
//   vga_r/g/b      grayscale pixel, black outside the image
//   frame_done     one-clock pulse after the last visible line has been scanned
// ---------------------------------------------------------------------------
module vga_frame_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  CURRENT_WIDTH,
  input  logic [9:0]  CURRENT_HEIGHT,
  input  logic [7:0]  color_in,
  output logic [18:0] rd_addr,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_done
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS_C    = 12'(H_VIS);
  localparam logic [11:0] V_VIS_C    = 12'(V_VIS);
  localparam logic [11:0] V_VIS_LAST = 12'(V_VIS - 1);
  localparam logic [11:0] HS_START   = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_VIS + V_FP + V_SYNC);

  // Raster position and per-frame image geometry
  logic [11:0] h_cnt_reg;
  logic [11:0] v_cnt_reg;
  logic [9:0]  w_lat_reg;
  logic [9:0]  h_lat_reg;

  // Incremental address: row_base_reg = (v-y0)*w, col_reg = h-x0
  logic [9:0]  col_reg;
  logic [18:0] row_base_reg;

  // Stage 1 (RAM read in flight) copies of the raster decode
  logic        in_image_d1_reg;
  logic        hsync_d1_reg;
  logic        vsync_d1_reg;
  logic        blank_n_d1_reg;

  logic        frame_start;
  logic        line_end;
  logic [9:0]  w_eff;
  logic [9:0]  h_eff;
  logic [11:0] w_ext;
  logic [11:0] h_ext;
  logic [11:0] x0;
  logic [11:0] y0;
  logic [11:0] x_end;
  logic [11:0] y_end;
  logic        dims_valid;
  logic        col_in;
  logic        row_in;
  logic        in_image;
  logic        hsync_now;
  logic        vsync_now;
  logic        blank_n_now;
  logic [7:0]  pixel;

  assign frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign line_end    = (h_cnt_reg == H_LAST);

  // The latch registers only update at the end of the first pixel clock, so
  // during that one clock the live inputs are the frame's dimensions.
  assign w_eff = frame_start ? CURRENT_WIDTH  : w_lat_reg;
  assign h_eff = frame_start ? CURRENT_HEIGHT : h_lat_reg;
  assign w_ext = {2'b00, w_eff};
  assign h_ext = {2'b00, h_eff};

  assign dims_valid = (w_eff != '0) && (w_ext <= H_VIS_C) &&
                      (h_eff != '0) && (h_ext <= V_VIS_C);

  // Origin is meaningless when the size is invalid; dims_valid masks it.
  assign x0    = (H_VIS_C - w_ext) >> 1;
  assign y0    = (V_VIS_C - h_ext) >> 1;
  assign x_end = x0 + w_ext;
  assign y_end = y0 + h_ext;

  assign col_in   = (h_cnt_reg >= x0) && (h_cnt_reg < x_end);
  assign row_in   = (v_cnt_reg >= y0) && (v_cnt_reg < y_end);
  assign in_image = dims_valid && col_in && row_in;

  assign rd_addr = in_image ? (row_base_reg + {9'b0, col_reg}) : '0;

  assign hsync_now   = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
  assign vsync_now   = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
  assign blank_n_now = (h_cnt_reg < H_VIS_C) && (v_cnt_reg < V_VIS_C);

  // Blank wins over image data so porches and sync are always black.
  assign pixel = (in_image_d1_reg && blank_n_d1_reg) ? color_in : 8'h00;

  // Raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (line_end) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 12'd1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 12'd1;
    end
  end

  // Frame geometry, sampled once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_lat_reg <= '0;
      h_lat_reg <= '0;
    end else if (frame_start) begin
      w_lat_reg <= CURRENT_WIDTH;
      h_lat_reg <= CURRENT_HEIGHT;
    end
  end

  // Address accumulators. The column counter sits at 0 until x0 is reached,
  // then counts one per pixel; the row base advances by the width at the end
  // of every image row and restarts at the end of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg      <= '0;
      row_base_reg <= '0;
    end else begin
      if (line_end) begin
        col_reg <= '0;
      end else if (dims_valid && col_in) begin
        col_reg <= col_reg + 10'd1;
      end

      if (line_end) begin
        if (v_cnt_reg == V_LAST) begin
          row_base_reg <= '0;
        end else if (dims_valid && row_in) begin
          row_base_reg <= row_base_reg + {7'b0, w_ext};
        end
      end
    end
  end

  // Stage 1: raster decode delayed to line up with the RAM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_image_d1_reg <= 1'b0;
      hsync_d1_reg    <= 1'b1;
      vsync_d1_reg    <= 1'b1;
      blank_n_d1_reg  <= 1'b0;
    end else begin
      in_image_d1_reg <= in_image;
      hsync_d1_reg    <= hsync_now;
      vsync_d1_reg    <= vsync_now;
      blank_n_d1_reg  <= blank_n_now;
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_done  <= 1'b0;
    end else begin
      vga_hsync   <= hsync_d1_reg;
      vga_vsync   <= vsync_d1_reg;
      vga_blank_n <= blank_n_d1_reg;
      vga_r       <= pixel;
      vga_g       <= pixel;
      vga_b       <= pixel;
      frame_done  <= line_end && (v_cnt_reg == V_VIS_LAST);
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_reader
//
// Drives vga_frame_reader with a reduced raster (64x48 visible, 80x55 total)
// so several whole frames fit in a short run. The full-size scenarios are
// scaled by 1/10: 160x120 becomes 16x12, 161x121 becomes 17x13, 320 becomes
// 32, and the illegal sizes become w=0, w=65 and h=49.
//
// The reference model tracks the raster position by counting clocks since
// reset release and computes the address with a multiply from the image
// geometry. Expected video is queued and compared two clocks later. The RAM
// model returns a hash of the address and a salt that changes at random
// mid-frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_frame_reader;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cur_w;
  logic [9:0]  cur_h;
  logic [7:0]  color_in;
  logic [18:0] rd_addr;
  logic        vga_hsync, vga_vsync, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        frame_done;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .CURRENT_WIDTH (cur_w),
    .CURRENT_HEIGHT(cur_h),
    .color_in      (color_in),
    .rd_addr       (rd_addr),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_blank_n   (vga_blank_n),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .frame_done    (frame_done)
  );

  int vectors     = 0;
  int miscompares = 0;

  // RAM model
  logic       ram_const = 1'b0;
  logic [7:0] salt      = 8'h00;

  function automatic logic [7:0] ram_f(input logic [18:0] a, input logic [7:0] s,
                                       input logic k);
    if (k) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ s ^ 8'h3C;
  endfunction

  always @(posedge clk) color_in <= ram_f(rd_addr, salt, ram_const);

  // Reference model state
  typedef struct {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   mh, mv, mw, mhh;
  int   obs_hs_low, obs_vs_low, obs_bl_high, obs_fd, last_fd, fd_interval, cyc;

  task automatic clear_stats();
    obs_hs_low = 0; obs_vs_low = 0; obs_bl_high = 0; obs_fd = 0;
    last_fd = -1; fd_interval = 0; cyc = 0;
  endtask

  // Hold reset for a few clocks, then release it on a falling edge with the
  // requested image size presented; the model restarts at (0,0).
  task automatic apply_reset(input int w, input int h);
    exp_t r;
    @(negedge clk);
    rst = 1'b1;
    cur_w = 10'(w);
    cur_h = 10'(h);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mh = 0; mv = 0;
    r.hs = 1'b1; r.vs = 1'b1; r.bl = 1'b0; r.rgb = 24'h0;
    q.delete();
    q.push_back(r);
    q.push_back(r);
  endtask

  // One pixel clock of model + comparison, entered and left on a falling edge.
  task automatic tick();
    int   x0, y0, ea;
    bit   valid, inimg;
    exp_t e, o;
    if ($urandom_range(0, 499) == 0) salt = 8'($urandom);
    if (mh == 0 && mv == 0) begin
      mw  = int'(cur_w);
      mhh = int'(cur_h);
    end
    valid = (mw >= 1) && (mw <= HV) && (mhh >= 1) && (mhh <= VV);
    x0 = (HV - mw) / 2;
    y0 = (VV - mhh) / 2;
    inimg = valid && (mh >= x0) && (mh < x0 + mw) && (mv >= y0) && (mv < y0 + mhh);
    ea = inimg ? (mv - y0) * mw + (mh - x0) : 0;

    vectors++;
    if (rd_addr !== 19'(ea)) begin
      miscompares++;
      $display("FAIL rd_addr at (%0d,%0d) w=%0d h=%0d: got %0d expected %0d",
               mh, mv, mw, mhh, rd_addr, ea);
    end

    e.hs  = !((mh >= HV + HF) && (mh < HV + HF + HS));
    e.vs  = !((mv >= VV + VF) && (mv < VV + VF + VS));
    e.bl  = (mh < HV) && (mv < VV);
    e.rgb = inimg ? {3{ram_f(19'(ea), salt, ram_const)}} : 24'h0;
    q.push_back(e);
    o = q.pop_front();

    vectors++;
    if ({vga_hsync, vga_vsync, vga_blank_n} !== {o.hs, o.vs, o.bl}) begin
      miscompares++;
      $display("FAIL sync at (%0d,%0d): got hs/vs/bl=%b%b%b expected %b%b%b",
               mh, mv, vga_hsync, vga_vsync, vga_blank_n, o.hs, o.vs, o.bl);
    end
    vectors++;
    if ({vga_r, vga_g, vga_b} !== o.rgb) begin
      miscompares++;
      $display("FAIL rgb at (%0d,%0d): got %h expected %h",
               mh, mv, {vga_r, vga_g, vga_b}, o.rgb);
    end
    vectors++;
    if (frame_done !== ((mh == 0) && (mv == VV))) begin
      miscompares++;
      $display("FAIL frame_done at (%0d,%0d): got %b expected %b",
               mh, mv, frame_done, (mh == 0) && (mv == VV));
    end

    if (!vga_hsync)  obs_hs_low++;
    if (!vga_vsync)  obs_vs_low++;
    if (vga_blank_n) obs_bl_high++;
    if (frame_done) begin
      obs_fd++;
      if (last_fd >= 0) fd_interval = cyc - last_fd;
      last_fd = cyc;
    end
    cyc++;

    @(posedge clk);
    @(negedge clk);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < HT * VT + 2 && !(mh == h && mv == v); i++) tick();
    vectors++;
    if (!(mh == h && mv == v)) begin
      miscompares++;
      $display("FAIL run_to: got position (%0d,%0d) expected (%0d,%0d)", mh, mv, h, v);
    end
  endtask

  task automatic test_reset();
    apply_reset(HV, VV);
    run_to(37, 5);
    rst = 1'b1;
    #1;
    vectors++;
    if ({rd_addr, vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b, frame_done} !==
        {19'd0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async: got addr=%0d hs=%b vs=%b bl=%b rgb=%h fd=%b expected 0/1/1/0/0/0",
               rd_addr, vga_hsync, vga_vsync, vga_blank_n, {vga_r, vga_g, vga_b}, frame_done);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({rd_addr, vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b} !==
        {19'd0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
      miscompares++;
      $display("FAIL reset_hold: got addr=%0d hs=%b vs=%b bl=%b rgb=%h expected 0/1/1/0/0",
               rd_addr, vga_hsync, vga_vsync, vga_blank_n, {vga_r, vga_g, vga_b});
    end
    apply_reset($urandom_range(1, HV), $urandom_range(1, VV));
    repeat (2 * HT * VT) tick();
  endtask

  task automatic test_timing();
    apply_reset($urandom_range(0, 100), $urandom_range(0, 60));
    clear_stats();
    repeat (2 * HT * VT) tick();
    vectors++;
    if (obs_hs_low != 2 * VT * HS) begin
      miscompares++;
      $display("FAIL hsync_low_count: got %0d expected %0d", obs_hs_low, 2 * VT * HS);
    end
    vectors++;
    if (obs_vs_low != 2 * VS * HT) begin
      miscompares++;
      $display("FAIL vsync_low_count: got %0d expected %0d", obs_vs_low, 2 * VS * HT);
    end
    vectors++;
    if (obs_bl_high != 2 * HV * VV) begin
      miscompares++;
      $display("FAIL blank_high_count: got %0d expected %0d", obs_bl_high, 2 * HV * VV);
    end
    vectors++;
    if (obs_fd != 2 || fd_interval != HT * VT) begin
      miscompares++;
      $display("FAIL frame_done_rate: got %0d pulses interval %0d expected 2 pulses interval %0d",
               obs_fd, fd_interval, HT * VT);
    end
  endtask

  task automatic test_image();
    apply_reset(16, 12);
    ram_const = 1'b1;
    run_to(23, 18);
    vectors++;
    if (rd_addr !== 19'd0) begin
      miscompares++;
      $display("FAIL img_left_addr: got %0d expected 0", rd_addr);
    end
    tick();
    tick();
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      miscompares++;
      $display("FAIL img_left_rgb: got %h expected 000000", {vga_r, vga_g, vga_b});
    end
    tick();
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'h5A5A5A) begin
      miscompares++;
      $display("FAIL img_first_rgb: got %h expected 5a5a5a", {vga_r, vga_g, vga_b});
    end
    run_to(39, 18);
    vectors++;
    if (rd_addr !== 19'd15) begin
      miscompares++;
      $display("FAIL img_row0_end_addr: got %0d expected 15", rd_addr);
    end
    tick();
    tick();
    tick();
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      miscompares++;
      $display("FAIL img_right_rgb: got %h expected 000000", {vga_r, vga_g, vga_b});
    end
    run_to(39, 29);
    vectors++;
    if (rd_addr !== 19'd191) begin
      miscompares++;
      $display("FAIL img_last_addr: got %0d expected 191", rd_addr);
    end
    tick();
    tick();
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'h5A5A5A) begin
      miscompares++;
      $display("FAIL img_last_rgb: got %h expected 5a5a5a", {vga_r, vga_g, vga_b});
    end
    run_to(0, 0);
    ram_const = 1'b0;
  endtask

  task automatic test_odd();
    apply_reset(17, 13);
    run_to(22, 17);
    vectors++;
    if (rd_addr !== 19'd0) begin
      miscompares++;
      $display("FAIL odd_outside_addr: got %0d expected 0", rd_addr);
    end
    run_to(24, 17);
    vectors++;
    if (rd_addr !== 19'd1) begin
      miscompares++;
      $display("FAIL odd_second_addr: got %0d expected 1", rd_addr);
    end
    run_to(39, 29);
    vectors++;
    if (rd_addr !== 19'd220) begin
      miscompares++;
      $display("FAIL odd_last_addr: got %0d expected 220", rd_addr);
    end
    run_to(0, 0);
  endtask

  task automatic test_dim_change();
    apply_reset(16, 12);
    run_to(0, 20);
    cur_w = 10'd32;
    run_to(23, 20);
    vectors++;
    if (rd_addr !== 19'd0) begin
      miscompares++;
      $display("FAIL chg_old_x0_addr: got %0d expected 0", rd_addr);
    end
    tick();
    vectors++;
    if (rd_addr !== 19'd32) begin
      miscompares++;
      $display("FAIL chg_old_stride_addr: got %0d expected 32", rd_addr);
    end
    run_to(16, 18);
    vectors++;
    if (rd_addr !== 19'd0) begin
      miscompares++;
      $display("FAIL chg_new_first_addr: got %0d expected 0", rd_addr);
    end
    run_to(16, 19);
    vectors++;
    if (rd_addr !== 19'd32) begin
      miscompares++;
      $display("FAIL chg_new_stride_addr: got %0d expected 32", rd_addr);
    end
    run_to(47, 19);
    vectors++;
    if (rd_addr !== 19'd63) begin
      miscompares++;
      $display("FAIL chg_new_row_end_addr: got %0d expected 63", rd_addr);
    end
    run_to(0, 0);
  endtask

  task automatic test_illegal();
    int ws[3] = '{0, HV + 1, 16};
    int hs[3] = '{12, 12, VV + 1};
    for (int k = 0; k < 3; k++) begin
      int nz;
      nz = 0;
      apply_reset(ws[k], hs[k]);
      clear_stats();
      repeat (HT * VT) begin
        tick();
        if (rd_addr !== 19'd0 || {vga_r, vga_g, vga_b} !== 24'h0) nz++;
      end
      vectors++;
      if (nz != 0) begin
        miscompares++;
        $display("FAIL illegal_black w=%0d h=%0d: got %0d non-zero cycles expected 0",
                 ws[k], hs[k], nz);
      end
      vectors++;
      if (obs_hs_low != VT * HS || obs_vs_low != VS * HT) begin
        miscompares++;
        $display("FAIL illegal_sync w=%0d h=%0d: got hs_low=%0d vs_low=%0d expected %0d %0d",
                 ws[k], hs[k], obs_hs_low, obs_vs_low, VT * HS, VS * HT);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    cur_w = 10'd0;
    cur_h = 10'd0;
    clear_stats();
    test_reset();
    $display("test_reset done");
    test_timing();
    $display("test_timing done");
    test_image();
    $display("test_image done");
    test_odd();
    $display("test_odd done");
    test_dim_change();
    $display("test_dim_change done");
    test_illegal();
    $display("test_illegal done");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
